fft4_sdf_ctrl: RTL and testbench

- Timing controller for the 4-point radix-2 single-path-delay-feedback FFT datapath.
- Accepts one 4-sample frame per start command and drives the delay-count inputs of the two delay lines (stage 1 and stage 2).
- Generates the per-cycle butterfly select, the -j twiddle select and the zero-fill strobe.
- Flags the output window once the pipeline has drained.

---
 rtl/fft4_sdf_ctrl.sv | 133 +++++++++++++
 tb/tb_fft4_sdf_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fft4_sdf_ctrl.sv
// Timing controller for the 4-point radix-2 SDF FFT: sequences one frame per start,
// drives the delay-line counts and the per-cycle butterfly/twiddle/zero-fill decodes.
module fft4_sdf_ctrl #(
   parameter int unsigned DNUM_W   = 4,
   parameter int unsigned STAGE1_D = 2,
   parameter int unsigned STAGE2_D = 1,
   parameter int unsigned PIPE_LAT = 2,
   parameter int unsigned FRAME_N  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DNUM_W-1:0] dnum1,
   output logic [DNUM_W-1:0] dnum2,
   output logic              bf1_sel,
   output logic              bf2_sel,
   output logic              tw_sel,
   output logic              zero_fill,
   output logic              out_valid,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned LAT = STAGE1_D + STAGE2_D + PIPE_LAT;

   localparam logic [3:0] T_LOAD_END  = 4'(FRAME_N - 1);
   localparam logic [3:0] T_FLUSH_END = 4'(LAT + FRAME_N - 1);
   localparam logic [3:0] T_S1        = 4'(STAGE1_D);
   localparam logic [3:0] T_BF1_END   = 4'(FRAME_N + STAGE1_D);
   localparam logic [3:0] T_BF2_END   = 4'(STAGE1_D + FRAME_N + STAGE2_D);
   localparam logic [3:0] T_OUT_START = 4'(LAT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        t_q, t_d;
   logic [DNUM_W-1:0] dnum1_q, dnum1_d;
   logic [DNUM_W-1:0] dnum2_q, dnum2_d;
   logic              err_q, err_d;
   logic [3:0]        s1;
   logic              active;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         t_q     <= '0;
         dnum1_q <= '0;
         dnum2_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         dnum1_q <= dnum1_d;
         dnum2_q <= dnum2_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      t_d       = t_q;
      dnum1_d   = dnum1_q;
      dnum2_d   = dnum2_q;
      err_d     = err_q;
      in_ready  = 1'b0;
      zero_fill = 1'b0;
      bf1_sel   = 1'b0;
      bf2_sel   = 1'b0;
      tw_sel    = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      active    = 1'b0;
      s1        = t_q - T_S1;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               t_d     = '0;
               dnum1_d = DNUM_W'(STAGE1_D);
               dnum2_d = DNUM_W'(STAGE2_D);
            end
         end
         S_LOAD: begin
            active   = 1'b1;
            in_ready = 1'b1;
            t_d      = t_q + 4'd1;
            // Delay lines free-run: a missing sample is replaced by zero, never stalled.
            if (!in_valid) begin
               zero_fill = 1'b1;
               err_d     = 1'b1;
            end
            if (t_q == T_LOAD_END) state_d = S_FLUSH;
         end
         S_FLUSH: begin
            active = 1'b1;
            t_d    = t_q + 4'd1;
            if (t_q == T_FLUSH_END) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (active) begin
         bf1_sel   = t_q[1] && (t_q < T_BF1_END);
         bf2_sel   = s1[0] && (t_q >= T_S1) && (t_q < T_BF2_END);
         // s1 wraps below STAGE1_D, so the -j slot is qualified by stage 2 being live.
         tw_sel    = (s1[1:0] == 2'd3) && (t_q >= T_S1) && (t_q < T_BF1_END);
         out_valid = (t_q >= T_OUT_START) && (t_q <= T_FLUSH_END);
         out_last  = (t_q == T_FLUSH_END);
      end
   end

   assign dnum1 = dnum1_q;
   assign dnum2 = dnum2_q;
   assign err   = err_q;
   assign busy  = (state_q != S_IDLE);
   assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_fft4_sdf_ctrl.sv
// Bench for fft4_sdf_ctrl: directed scenarios plus random start/in_valid traffic,
// compared each cycle against a frame-position reference model.
module tb_fft4_sdf_ctrl;

   localparam int LAT = 5;
   localparam int FN  = 4;

   logic       clk = 1'b0;
   logic       rst, start, in_valid;
   logic       in_ready, bf1_sel, bf2_sel, tw_sel, zero_fill;
   logic       out_valid, out_last, busy, done, err;
   logic [3:0] dnum1, dnum2;

   int errors = 0;
   int checks = 0;

   // Model: k = -1 when idle, else cycles since the frame was accepted (0..9).
   int         k;
   bit         err_m;
   logic [3:0] d1_m, d2_m;

   fft4_sdf_ctrl #(
      .DNUM_W(4), .STAGE1_D(2), .STAGE2_D(1), .PIPE_LAT(2), .FRAME_N(4)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .in_ready(in_ready), .dnum1(dnum1), .dnum2(dnum2),
      .bf1_sel(bf1_sel), .bf2_sel(bf2_sel), .tw_sel(tw_sel),
      .zero_fill(zero_fill), .out_valid(out_valid), .out_last(out_last),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s (k=%0d): got %03h expected %03h", tag, k, obs, exp);
      end
   endtask

   function automatic logic [9:0] obs_ctl();
      return {in_ready, zero_fill, bf1_sel, bf2_sel, tw_sel,
              out_valid, out_last, busy, done, err};
   endfunction

   function automatic logic [9:0] exp_ctl(input int kk, input bit iv, input bit em);
      bit ld, fl, act, b1, b2, tw, ov, ol;
      int t;
      t   = kk;
      ld  = (kk >= 0) && (kk < FN);
      fl  = (kk >= FN) && (kk <= LAT + FN - 1);
      act = ld || fl;
      b1  = act && (t < FN + 2) && ((t / 2) % 2 == 1);
      b2  = act && (t >= 2) && (t < 2 + FN + 1) && ((t - 2) % 2 == 1);
      tw  = act && (t >= 2) && (t < FN + 2) && ((t - 2) % 4 == 3);
      ov  = act && (t >= LAT) && (t <= LAT + 3);
      ol  = act && (t == LAT + 3);
      return {ld, ld && !iv, b1, b2, tw, ov, ol, kk >= 0, kk == LAT + FN, em};
   endfunction

   task automatic step(input string tag, input bit st, input bit iv);
      start    = st;
      in_valid = iv;
      @(negedge clk);
      check_val(tag, 32'(obs_ctl()), 32'(exp_ctl(k, iv, err_m)));
      check_val({tag, "_dnum"}, {24'd0, dnum1, dnum2}, {24'd0, d1_m, d2_m});
      @(posedge clk);
      if (k >= 0 && k < FN && !iv) err_m = 1'b1;
      if (k < 0) begin
         if (st) begin
            k    = 0;
            d1_m = 4'd2;
            d2_m = 4'd1;
         end
      end else begin
         k = (k == LAT + FN) ? -1 : k + 1;
      end
      #1;
   endtask

   task automatic model_reset();
      k     = -1;
      err_m = 1'b0;
      d1_m  = '0;
      d2_m  = '0;
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      model_reset();
      #3;
      check_val("reset", 32'(obs_ctl()), 32'd0);
      check_val("reset_dnum", {24'd0, dnum1, dnum2}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Nominal frame.
      step("idle", 1'b0, 1'b0);
      step("nom", 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) step("nom", 1'b0, i < 4);
      step("idle", 1'b0, 1'b0);

      // Underrun at t = 1.
      step("und", 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) step("und", 1'b0, i != 1);
      step("idle", 1'b0, 1'b1);

      // Start held through the whole frame, then released.
      step("hold", 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) step("hold", 1'b1, 1'b1);
      step("hold", 1'b0, 1'b1);
      step("hold", 1'b0, 1'b1);

      // Back-to-back: restart in the idle cycle right after done.
      step("b2b", 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) step("b2b", 1'b0, 1'b1);
      step("b2b", 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) step("b2b", 1'b0, 1'b1);

      // Reset asserted during LOAD at t = 2.
      step("rmid", 1'b1, 1'b1);
      step("rmid", 1'b0, 1'b1);
      step("rmid", 1'b0, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check_val("rmid_async", 32'(obs_ctl()), 32'd0);
      check_val("rmid_dnum", {24'd0, dnum1, dnum2}, 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 12; i++) step("after_rst", 1'b0, 1'b1);

      // Random traffic.
      for (int i = 0; i < 400; i++)
         step("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
